dm_lsu: RTL and testbench

Data-memory load/store unit sitting in the MEM stage of the pipelined RV32I core, consuming the memory-control signals produced by the instruction decoder (`mem_read`, `MemWrite`, `DMType`). It turns one decoded load/store into a single word-wide bus transaction with byte enables, and returns sign- or zero-extended load data. It stalls the pipeline with a request/ready handshake until the bus responds. Misaligned accesses are flagged and never reach the bus.

---
 rtl/dm_lsu.sv | 134 +++++++++++++
 tb/tb_dm_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Data-memory load/store unit for the MEM stage: one decoded load/store becomes a
// single word-wide bus transaction with byte enables; load data is extended and registered.
module dm_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [2:0]  type_q;
  logic [1:0]  off_q;

  logic        req_any;
  logic        is_half;
  logic        is_byte;
  logic        aligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  // Request decode, alignment, lane steering for the incoming access
  always_comb begin
    req_any = mem_read | mem_write;
    is_half = (dm_type == 3'b001) || (dm_type == 3'b010);
    is_byte = (dm_type == 3'b011) || (dm_type == 3'b100);
    if (is_byte)      aligned = 1'b1;
    else if (is_half) aligned = ~addr[0];
    else              aligned = (addr[1:0] == 2'b00);

    if (is_byte) begin
      be_n    = 4'b0001 << addr[1:0];
      wdata_n = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_n    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_n = {2{wdata[15:0]}};
    end else begin
      be_n    = 4'b1111;
      wdata_n = wdata;
    end
  end

  // Load extraction uses the latched type/offset, not the live pipeline inputs
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (type_q)
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_ext = {16'h0000, lane_h};
      3'b011:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h000000, lane_b};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    lsu_stall = (state == REQ) || ((state == IDLE) && req_any);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      type_q    <= '0;
      off_q     <= '0;
      rdata     <= '0;
      lsu_done  <= 1'b0;
      misalign  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      lsu_done <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (aligned) begin
              bus_we    <= mem_write;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= be_n;
              bus_wdata <= wdata_n;
              type_q    <= dm_type;
              off_q     <= addr[1:0];
              bus_req   <= 1'b1;
              state     <= REQ;
            end else begin
              misalign <= 1'b1;
              lsu_done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            if (!bus_we) rdata <= load_ext;
            bus_req  <= 1'b0;
            lsu_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: a small bus responder with wait-state control,
// and a scoreboard of expected load results / misalign flags per access.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write;
  logic [2:0]  dm_type;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        lsu_stall, lsu_done, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  dm_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write),
    .dm_type(dm_type), .addr(addr), .wdata(wdata), .rdata(rdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] model_rdata;
  logic [31:0] mem [logic [31:0]];

  int          wait_cnt = 0;
  int          txn = 0;
  int          req_cycles = 0;
  logic        unstable = 1'b0;
  logic        prev_req = 1'b0;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_be = '0;

  // Bus responder: ready/data presented on the falling edge, sampled by the DUT on the rising edge
  always @(negedge clk) begin
    if (bus_req) begin
      req_cycles++;
      if (!prev_req) begin
        snap_we = bus_we; snap_addr = bus_addr; snap_be = bus_be; snap_wdata = bus_wdata;
      end else if (snap_we !== bus_we || snap_addr !== bus_addr ||
                   snap_be !== bus_be || snap_wdata !== bus_wdata) begin
        unstable = 1'b1;
      end
      bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        bus_ready = 1'b0;
      end else begin
        bus_ready = 1'b1;
      end
    end else begin
      bus_ready = 1'b0;
    end
    prev_req = bus_req;
  end

  always @(posedge clk) begin
    if (rstn && bus_req && bus_ready) begin
      logic [31:0] m;
      txn++;
      last_we = bus_we; last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata;
      if (bus_we) begin
        m = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
        for (int unsigned i = 0; i < 4; i++)
          if (bus_be[i]) m[8*i +: 8] = bus_wdata[8*i +: 8];
        mem[bus_addr] = m;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [2:0] t, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] s;
    case (t)
      3'd1: begin s = w >> (16 * off[1]); return {{16{s[15]}}, s[15:0]}; end
      3'd2: begin s = w >> (16 * off[1]); return {16'h0000, s[15:0]}; end
      3'd3: begin s = w >> (8 * off);     return {{24{s[7]}}, s[7:0]}; end
      3'd4: begin s = w >> (8 * off);     return {24'h000000, s[7:0]}; end
      default: return w;
    endcase
  endfunction

  function automatic logic is_mis(input logic [2:0] t, input logic [1:0] off);
    if (t == 3'd1 || t == 3'd2) return off[0];
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    return off != 2'b00;
  endfunction

  // One access presented until its done pulse; word = value the bus should return for a load
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int waits, input int exp_stalls);
    int   stalls = 0;
    int   cyc = 0;
    int   req0;
    exp_t e;
    exp_t got;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd;
    wait_cnt = waits;
    unstable = 1'b0;
    e.mis = is_mis(t, a[1:0]);
    if (!e.mis && rd && !wr) model_rdata = ext_model(t, a[1:0], word);
    e.rd = model_rdata;
    sb_q.push_back(e);
    req0 = req_cycles;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (lsu_done) break;
      if (lsu_stall) stalls++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    got = sb_q.pop_front();
    check({tag, "_done"}, lsu_done, 1'b1);
    check({tag, "_misalign"}, misalign, got.mis);
    check({tag, "_rdata"}, rdata, got.rd);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_stall_at_done"}, lsu_stall, 1'b0);
    check({tag, "_stable"}, unstable, 1'b0);
    if (got.mis) check({tag, "_no_req"}, req_cycles - req0, 0);
  endtask

  initial begin
    int t0;
    logic done_seen;
    rstn = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; dm_type = '0; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    model_rdata = '0;
    mem[32'h100] = 32'h8077F0A5;
    mem[32'h200] = 32'hDEADBEEF;
    #12;
    check("rst_rdata", rdata, 0);
    check("rst_done", lsu_done, 0);
    check("rst_misalign", misalign, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_stall", lsu_stall, 0);
    @(negedge clk); rstn = 1'b1;

    access("lb",  1, 0, 3'd3, 32'h103, 0, 32'h8077F0A5, 0, 2);
    check("lb_val", rdata, 32'hFFFFFF80);
    access("lh",  1, 0, 3'd1, 32'h100, 0, 32'h8077F0A5, 0, 2);
    check("lh_val", rdata, 32'hFFFFF0A5);
    access("lhu", 1, 0, 3'd2, 32'h102, 0, 32'h8077F0A5, 0, 2);
    check("lhu_val", rdata, 32'h00008077);
    access("lbu", 1, 0, 3'd4, 32'h101, 0, 32'h8077F0A5, 0, 2);
    check("lbu_val", rdata, 32'h000000F0);
    access("lw_wait", 1, 0, 3'd0, 32'h200, 0, 32'hDEADBEEF, 3, 5);
    check("lw_val", rdata, 32'hDEADBEEF);

    access("sb", 0, 1, 3'd3, 32'h101, 32'h12345678, 0, 0, 2);
    check("sb_we", last_we, 1);
    check("sb_be", last_be, 4'b0010);
    check("sb_wdata", last_wdata, 32'h78787878);
    check("sb_addr", last_addr, 32'h100);
    access("sh", 0, 1, 3'd1, 32'h102, 32'h12345678, 0, 0, 2);
    check("sh_be", last_be, 4'b1100);
    check("sh_wdata", last_wdata, 32'h56785678);
    check("sh_addr", last_addr, 32'h100);

    t0 = txn;
    access("mis_lw", 1, 0, 3'd0, 32'h102, 0, 0, 0, 1);
    access("mis_sh", 0, 1, 3'd1, 32'h101, 32'h0, 0, 0, 1);
    check("mis_no_txn", txn - t0, 0);

    t0 = txn;
    access("both", 1, 1, 3'd0, 32'h10, 32'hA5A55A5A, 0, 0, 2);
    check("both_we", last_we, 1);
    check("both_addr", last_addr, 32'h10);
    check("both_txn", txn - t0, 1);

    t0 = txn;
    access("b2b_sw", 0, 1, 3'd0, 32'h300, 32'hCAFEF00D, 0, 0, 2);
    access("b2b_lw", 1, 0, 3'd0, 32'h300, 0, 32'hCAFEF00D, 0, 2);
    check("b2b_txn", txn - t0, 2);

    // Reset while stuck in REQ
    @(posedge clk); #1;
    mem_read = 1'b1; dm_type = 3'd0; addr = 32'h200; wait_cnt = 10;
    @(negedge clk);
    @(negedge clk);
    check("rreq_active", bus_req, 1);
    #2 rstn = 1'b0;
    #1;
    check("rreq_async_drop", bus_req, 0);
    check("rreq_rdata", rdata, 0);
    mem_read = 1'b0;
    model_rdata = '0;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (lsu_done) done_seen = 1'b1;
    end
    rstn = 1'b1;
    wait_cnt = 0;
    @(negedge clk);
    if (lsu_done) done_seen = 1'b1;
    check("rreq_no_done", done_seen, 0);
    // Byte 1 and upper half of 0x100 were rewritten by the sb/sh above
    access("post_rst_lhu", 1, 0, 3'd2, 32'h102, 0, 32'h567878A5, 0, 2);
    check("post_rst_val", rdata, 32'h00005678);
    access("post_rst_lb", 1, 0, 3'd3, 32'h101, 0, 32'h567878A5, 1, 3);
    check("post_rst_lb_val", rdata, 32'h00000078);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
